// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// width helpers and address-field extraction.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_REFILL,
    ST_DRAIN
  } icache_state_e;

  // Byte-offset bits below the word offset (word-aligned fetch)
  localparam int BYTE_W = 2;

  // Number of address bits needed to select one of n items (0 when n == 1)
  function automatic int field_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Vectors cannot be zero wide, so any field that may vanish is kept at 1 bit
  function automatic int min1(input int w);
    return (w > 0) ? w : 1;
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - BYTE_W - field_bits(line_words) - field_bits(sets);
  endfunction

  // Beat/drain counters must be able to hold the value LINE_WORDS itself
  function automatic int cnt_bits(input int line_words);
    return $clog2(line_words + 1);
  endfunction

  // Field extraction works on a zero-extended 64-bit address; callers cast down
  function automatic logic [63:0] addr_word_off(input logic [63:0] addr, input int line_words);
    return (addr >> BYTE_W) & (64'(line_words) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int line_words,
                                             input int sets);
    return (addr >> (BYTE_W + field_bits(line_words))) & (64'(sets) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int line_words,
                                           input int sets);
    return addr >> (BYTE_W + field_bits(line_words) + field_bits(sets));
  endfunction

endpackage

// File: rtl/icache_way_store.sv
// One cache way: valid bits, tags and line data per set, with combinational
// lookup and a synchronous whole-line write.
module icache_way_store
  import icache_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 22,
  parameter int OFF_W      = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              en,
  input  logic                              clear,
  input  logic [IDX_W-1:0]                  rd_idx,
  input  logic [TAG_W-1:0]                  rd_tag,
  input  logic [OFF_W-1:0]                  rd_off,
  output logic                              hit,
  output logic [WORD_W-1:0]                 rd_word,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic [TAG_W-1:0]                  wr_tag,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0] wr_line
);

  logic [SETS-1:0]                  valid_q;
  logic [TAG_W-1:0]                 tag_q  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0] data_q [SETS];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_word = data_q[rd_idx][rd_off];

  // Valid bits: a clear (fence.i) beats a simultaneous line install
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (en) begin
      if (clear) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are plain storage, qualified only by the valid bits
  always_ff @(posedge clk_in) begin
    if (en && wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word lines, line-burst
// refill, flush-safe draining of outstanding bursts and fence.i invalidation.
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              invalidate_in,
  input  logic              fetch_valid_in,
  input  logic [ADDR_W-1:0] fetch_addr_in,
  output logic              fetch_ready_out,
  output logic              resp_valid_out,
  output logic [WORD_W-1:0] resp_data_out,
  output logic [ADDR_W-1:0] resp_pc_out,
  output logic              mem_req_valid_out,
  output logic [ADDR_W-1:0] mem_req_addr_out,
  input  logic              mem_req_ready_in,
  input  logic              mem_resp_valid_in,
  input  logic [WORD_W-1:0] mem_resp_data_in
);
  import icache_pkg::*;

  localparam int OFF_W = min1(field_bits(LINE_WORDS));
  localparam int IDX_W = field_bits(SETS);
  localparam int TAG_W = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W = min1(field_bits(WAYS));
  localparam int CNT_W = cnt_bits(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  icache_state_e     state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, mem_req_addr_q, resp_pc_q;
  logic [WORD_W-1:0] resp_data_q;
  logic              resp_valid_q, stale_q;
  logic [CNT_W-1:0]  beat_cnt_q, drain_cnt_q, drain_cnt_d;
  line_t             line_buf_q, fill_line;
  logic [WAY_W-1:0]  victim_q [SETS];

  logic [IDX_W-1:0]  f_idx, r_idx;
  logic [TAG_W-1:0]  f_tag, r_tag;
  logic [OFF_W-1:0]  f_off, r_off;
  logic [WAYS-1:0]   way_hit, way_wr;
  logic [WORD_W-1:0] way_word [WAYS];
  logic [WORD_W-1:0] hit_word;
  logic [WAY_W-1:0]  victim_way;
  logic              hit, beat_wr, last_beat;
  logic              accept_hit, accept_miss, req_fire, refill_resp, install;

  assign f_off = OFF_W'(addr_word_off(64'(fetch_addr_in), LINE_WORDS));
  assign f_idx = IDX_W'(addr_index(64'(fetch_addr_in), LINE_WORDS, SETS));
  assign f_tag = TAG_W'(addr_tag(64'(fetch_addr_in), LINE_WORDS, SETS));
  assign r_off = OFF_W'(addr_word_off(64'(req_pc_q), LINE_WORDS));
  assign r_idx = IDX_W'(addr_index(64'(req_pc_q), LINE_WORDS, SETS));
  assign r_tag = TAG_W'(addr_tag(64'(req_pc_q), LINE_WORDS, SETS));

  assign victim_way = victim_q[r_idx];
  assign beat_wr    = (state_q == ST_REFILL) && mem_resp_valid_in;
  assign last_beat  = beat_wr && (beat_cnt_q == CNT_W'(LINE_WORDS - 1));
  assign req_fire   = (state_q == ST_REQ) && mem_req_ready_in;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_wr[w] = install && (victim_way == WAY_W'(w));

    icache_way_store #(
      .WORD_W    (WORD_W),
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W),
      .OFF_W     (OFF_W)
    ) u_way (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .en      (rdy_in),
      .clear   (invalidate_in),
      .rd_idx  (f_idx),
      .rd_tag  (f_tag),
      .rd_off  (f_off),
      .hit     (way_hit[w]),
      .rd_word (way_word[w]),
      .wr_en   (way_wr[w]),
      .wr_idx  (r_idx),
      .wr_tag  (r_tag),
      .wr_line (fill_line)
    );
  end

  // One-hot OR mux across the ways; at most one way can hit a given set
  always_comb begin
    hit      = |way_hit;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_word = hit_word | way_word[w];
    end
  end

  // Line buffer with the beat arriving this cycle merged in, so the last beat
  // can be installed and returned without an extra cycle
  always_comb begin
    fill_line = line_buf_q;
    if (beat_wr) fill_line[beat_cnt_q[OFF_W-1:0]] = mem_resp_data_in;
  end

  // Next-state logic; a flush always suppresses accepts and responses
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    refill_resp = 1'b0;
    install     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_valid_in && !flush_in) begin
          if (hit) begin
            accept_hit = 1'b1;
          end else begin
            accept_miss = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (flush_in) begin
          state_d     = req_fire ? ST_DRAIN : ST_IDLE;
          drain_cnt_d = CNT_W'(LINE_WORDS);
        end else if (req_fire) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (flush_in) begin
          state_d     = last_beat ? ST_IDLE : ST_DRAIN;
          drain_cnt_d = CNT_W'(LINE_WORDS) - beat_cnt_q - CNT_W'(beat_wr);
        end else if (last_beat) begin
          state_d     = ST_IDLE;
          refill_resp = 1'b1;
          install     = !stale_q && !invalidate_in;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid_in) begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
          if (drain_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers: FSM state, beat/drain counters and stale-line flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (req_fire) begin
        beat_cnt_q <= '0;
      end else if (beat_wr) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
      if (accept_miss) begin
        stale_q <= 1'b0;
      end else if (invalidate_in && (state_q == ST_REQ || state_q == ST_REFILL)) begin
        stale_q <= 1'b1;
      end
    end
  end

  // Datapath registers: response, latched miss PC, request address, line buffer
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_pc_q      <= '0;
      req_pc_q       <= '0;
      mem_req_addr_q <= '0;
      line_buf_q     <= '0;
    end else if (rdy_in) begin
      resp_valid_q <= 1'b0;
      if (accept_hit) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= hit_word;
        resp_pc_q    <= fetch_addr_in;
      end else if (refill_resp) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= fill_line[r_off];
        resp_pc_q    <= req_pc_q;
      end
      if (accept_miss) begin
        req_pc_q       <= fetch_addr_in;
        mem_req_addr_q <= fetch_addr_in & LINE_MASK;
      end
      if (beat_wr) line_buf_q <= fill_line;
    end
  end

  // Round-robin victim pointers, reset together with the valid bits on fence.i
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
    end else if (rdy_in) begin
      if (invalidate_in) begin
        for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
      end else if (install) begin
        victim_q[r_idx] <= (victim_way == WAY_W'(WAYS - 1)) ? '0 : victim_way + WAY_W'(1);
      end
    end
  end

  assign fetch_ready_out   = rst_n_in && (state_q == ST_IDLE);
  assign mem_req_valid_out = (state_q == ST_REQ);
  assign mem_req_addr_out  = mem_req_addr_q;
  assign resp_valid_out    = resp_valid_q;
  assign resp_data_out     = resp_data_q;
  assign resp_pc_out       = resp_pc_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: hits, refills, eviction, flush/drain,
// invalidation and asynchronous reset mid-refill.
module tb_icache_assoc;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        invalidate_in = 1'b0;
  logic        fetch_valid_in = 1'b0;
  logic [31:0] fetch_addr_in = '0;
  logic        fetch_ready_out;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;
  logic [31:0] resp_pc_out;
  logic        mem_req_valid_out;
  logic [31:0] mem_req_addr_out;
  logic        mem_req_ready_in = 1'b0;
  logic        mem_resp_valid_in = 1'b0;
  logic [31:0] mem_resp_data_in = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  icache_assoc #(
    .ADDR_W    (32),
    .WORD_W    (32),
    .SETS      (64),
    .WAYS      (2),
    .LINE_WORDS(4)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rdy_in           (rdy_in),
    .flush_in         (flush_in),
    .invalidate_in    (invalidate_in),
    .fetch_valid_in   (fetch_valid_in),
    .fetch_addr_in    (fetch_addr_in),
    .fetch_ready_out  (fetch_ready_out),
    .resp_valid_out   (resp_valid_out),
    .resp_data_out    (resp_data_out),
    .resp_pc_out      (resp_pc_out),
    .mem_req_valid_out(mem_req_valid_out),
    .mem_req_addr_out (mem_req_addr_out),
    .mem_req_ready_in (mem_req_ready_in),
    .mem_resp_valid_in(mem_resp_valid_in),
    .mem_resp_data_in (mem_resp_data_in)
  );

  always #5 clk_in = ~clk_in;

  // Backing-store contents: a distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Response monitor: every response must match the oldest scoreboard entry
  always @(negedge clk_in) begin
    if (resp_valid_out) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_resp", 64'(resp_valid_out), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("resp_pc", 64'(resp_pc_out), 64'(e.pc));
        checkOutput("resp_data", 64'(resp_data_out), 64'(e.data));
      end
    end
  end

  // All driving tasks start and end just after a falling edge
  task automatic applyStimulus(input logic [31:0] addr);
    fetch_valid_in = 1'b1;
    fetch_addr_in  = addr;
    checkOutput("fetch_ready", 64'(fetch_ready_out), 64'd1);
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic waitReq(input logic [31:0] line);
    int n = 0;
    while (!mem_req_valid_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("req_seen", 64'(mem_req_valid_out), 64'd1);
    checkOutput("req_addr", 64'(mem_req_addr_out), 64'(line));
  endtask

  task automatic handshake(input logic with_flush);
    mem_req_ready_in = 1'b1;
    flush_in         = with_flush;
    @(negedge clk_in);
    mem_req_ready_in = 1'b0;
    flush_in         = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] data, input logic with_flush,
                          input logic with_inv);
    mem_resp_valid_in = 1'b1;
    mem_resp_data_in  = data;
    flush_in          = with_flush;
    invalidate_in     = with_inv;
    @(negedge clk_in);
    mem_resp_valid_in = 1'b0;
    flush_in          = 1'b0;
    invalidate_in     = 1'b0;
  endtask

  task automatic checkHit(input logic [31:0] addr);
    sb_q.push_back('{pc: addr, data: mem_word(addr)});
    applyStimulus(addr);
    checkOutput("hit_latency", 64'(resp_valid_out), 64'd1);
    checkOutput("hit_no_req", 64'(mem_req_valid_out), 64'd0);
  endtask

  // Full miss and refill; inv_at selects a beat that carries an invalidate (-1: none)
  task automatic fullMiss(input logic [31:0] addr, input int inv_at);
    logic [31:0] line;
    line = addr & ~32'hF;
    applyStimulus(addr);
    waitReq(line);
    handshake(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back('{pc: addr, data: mem_word(addr)});
      sendBeat(mem_word(line + 32'(i * 4)), 1'b0, 1'(i == inv_at));
    end
    checkOutput("miss_resp", 64'(resp_valid_out), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    idleCycles(3);
    checkOutput("rst_ready_low", 64'(fetch_ready_out), 64'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checkOutput("rst_resp_valid", 64'(resp_valid_out), 64'd0);
    checkOutput("rst_req_valid", 64'(mem_req_valid_out), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data_out), 64'd0);
    checkOutput("rst_resp_pc", 64'(resp_pc_out), 64'd0);
    checkOutput("rst_req_addr", 64'(mem_req_addr_out), 64'd0);
    checkOutput("rst_ready", 64'(fetch_ready_out), 64'd1);

    $display("[TB] cold miss, hit, back-to-back hits");
    fullMiss(32'h1000, -1);
    checkHit(32'h1008);
    sb_q.push_back('{pc: 32'h1004, data: mem_word(32'h1004)});
    fetch_valid_in = 1'b1;
    fetch_addr_in  = 32'h1004;
    @(negedge clk_in);
    sb_q.push_back('{pc: 32'h100C, data: mem_word(32'h100C)});
    fetch_addr_in = 32'h100C;
    checkOutput("b2b_first", 64'(resp_valid_out), 64'd1);
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    checkOutput("b2b_second", 64'(resp_valid_out), 64'd1);

    $display("[TB] round-robin eviction in one set");
    fullMiss(32'h2000, -1);
    fullMiss(32'h300C, -1);
    checkHit(32'h2004);
    fullMiss(32'h1000, -1);
    checkHit(32'h3000);

    $display("[TB] flush blocks a simultaneous hit");
    fetch_valid_in = 1'b1;
    fetch_addr_in  = 32'h3000;
    flush_in       = 1'b1;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    flush_in       = 1'b0;
    checkOutput("flush_blocks_hit", 64'(resp_valid_out), 64'd0);

    $display("[TB] flush after two beats drains the rest");
    applyStimulus(32'h4010);
    waitReq(32'h4010);
    handshake(1'b0);
    sendBeat(mem_word(32'h4010), 1'b0, 1'b0);
    sendBeat(mem_word(32'h4014), 1'b0, 1'b0);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    checkOutput("drain_busy", 64'(fetch_ready_out), 64'd0);
    sendBeat(mem_word(32'h4018), 1'b0, 1'b0);
    checkOutput("drain_busy2", 64'(fetch_ready_out), 64'd0);
    sendBeat(mem_word(32'h401C), 1'b0, 1'b0);
    checkOutput("drain_done", 64'(fetch_ready_out), 64'd1);
    idleCycles(2);
    fullMiss(32'h4010, -1);

    $display("[TB] flush with the last beat");
    applyStimulus(32'h4024);
    waitReq(32'h4020);
    handshake(1'b0);
    for (int i = 0; i < 3; i++) sendBeat(mem_word(32'h4020 + 32'(i * 4)), 1'b0, 1'b0);
    sendBeat(mem_word(32'h402C), 1'b1, 1'b0);
    checkOutput("flush_last_idle", 64'(fetch_ready_out), 64'd1);
    checkOutput("flush_last_noresp", 64'(resp_valid_out), 64'd0);
    idleCycles(2);
    fullMiss(32'h4024, -1);

    $display("[TB] flush in REQ without and with handshake");
    applyStimulus(32'h5000);
    waitReq(32'h5000);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    checkOutput("req_flush_drop", 64'(mem_req_valid_out), 64'd0);
    checkOutput("req_flush_idle", 64'(fetch_ready_out), 64'd1);
    applyStimulus(32'h5010);
    waitReq(32'h5010);
    handshake(1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hs_flush_drain", 64'(fetch_ready_out), 64'd0);
      sendBeat(mem_word(32'h5010 + 32'(i * 4)), 1'b0, 1'b0);
    end
    checkOutput("hs_flush_done", 64'(fetch_ready_out), 64'd1);
    idleCycles(2);

    $display("[TB] invalidate when idle and during refill");
    checkHit(32'h1000);
    invalidate_in = 1'b1;
    @(negedge clk_in);
    invalidate_in = 1'b0;
    fullMiss(32'h1000, -1);
    fullMiss(32'h2008, 1);
    fullMiss(32'h2008, -1);

    $display("[TB] asynchronous reset mid-refill");
    applyStimulus(32'h6000);
    waitReq(32'h6000);
    handshake(1'b0);
    sendBeat(mem_word(32'h6000), 1'b0, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("arst_resp_valid", 64'(resp_valid_out), 64'd0);
    checkOutput("arst_resp_data", 64'(resp_data_out), 64'd0);
    checkOutput("arst_resp_pc", 64'(resp_pc_out), 64'd0);
    checkOutput("arst_req_valid", 64'(mem_req_valid_out), 64'd0);
    checkOutput("arst_req_addr", 64'(mem_req_addr_out), 64'd0);
    checkOutput("arst_ready", 64'(fetch_ready_out), 64'd0);
    idleCycles(2);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checkOutput("arst_ready_after", 64'(fetch_ready_out), 64'd1);
    fullMiss(32'h6000, -1);

    idleCycles(2);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
